// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared types and constants for the tick generator.
//   tick_state_t : FSM encoding (HOLD = reset stretch, IDLE = stopped, RUN = ticking)
//   TICK_CNT_W   : width of the optional tick counter (TICK_CNT_EN)
//   sat_inc      : saturating increment for the tick counter
package tick_gen_pkg;

   typedef enum logic [1:0] {HOLD, IDLE, RUN} tick_state_t;

   localparam int TICK_CNT_W = 16;

   function automatic logic [TICK_CNT_W-1:0] sat_inc(input logic [TICK_CNT_W-1:0] v);
      return (v == {TICK_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rst_stretch.sv
// rst_stretch: holds rst_out high for RST_CYCLES edges after rst deasserts.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   rst_out out registered stretched reset
//   done    out combinational; high on the edge where rst_out will fall
module rst_stretch #(
   parameter int RST_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   output logic rst_out,
   output logic done
);

   localparam int CW = $clog2(RST_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          rst_out_q;

   // Counting starts on the first edge that sees rst low; the edge that
   // finds the counter at RST_CYCLES-1 is the RST_CYCLES-th such edge.
   assign done  = rst_out_q && !rst && (cnt_q == CW'(RST_CYCLES - 1));
   assign cnt_d = rst_out_q ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         rst_out_q <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         if (done) rst_out_q <= 1'b0;
      end
   end

   assign rst_out = rst_out_q;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: stretched reset plus a periodic one-cycle tick at a runtime
// programmable divide ratio.
//   clk, rst   clock and synchronous active-high reset
//   run        level, high = generate ticks
//   div_load   one-cycle request to load div_in as the new ratio
//   div_in     new ratio (0 is rejected with div_err)
//   div_ack    pulse when a new ratio takes effect
//   div_err    pulse when a load is rejected
//   tick       one-cycle enable every div_reg cycles while running
//   phase      position within the current period, 0..div_reg-1
//   rst_out    stretched reset for downstream logic
//   busy       high while in RUN
//   tick_cnt   saturating tick count (only with TICK_CNT_EN defined)
// Handshake: div_load is a single-cycle strobe with no back-pressure; each
// accepted strobe is answered later by exactly one div_ack or div_err pulse,
// except that a load overwriting a still-pending load shares its ack.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int DW         = 8,
   parameter int DEF_DIV    = 4,
   parameter int RST_CYCLES = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          div_load,
   input  logic [DW-1:0] div_in,
   output logic          div_ack,
   output logic          div_err,
   output logic          tick,
   output logic [DW-1:0] phase,
   output logic          rst_out,
`ifdef TICK_CNT_EN
   output logic [TICK_CNT_W-1:0] tick_cnt,
`endif
   output logic          busy
);

   tick_state_t   state_q;
   logic [DW-1:0] phase_q, div_q, pend_val_q;
   logic          pend_q, tick_q, ack_q, err_q, busy_q;
   logic          hold_done;
   logic          load_ok, load_bad, wrap;
`ifdef TICK_CNT_EN
   logic [TICK_CNT_W-1:0] cnt_q;
`endif

   rst_stretch #(.RST_CYCLES(RST_CYCLES)) u_rst_stretch (
      .clk     (clk),
      .rst     (rst),
      .rst_out (rst_out),
      .done    (hold_done)
   );

   assign load_ok  = div_load && (div_in != '0);
   assign load_bad = div_load && (div_in == '0);
   assign wrap     = (phase_q == div_q - 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HOLD;
         phase_q    <= '0;
         div_q      <= DW'(DEF_DIV);
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef TICK_CNT_EN
         cnt_q      <= '0;
`endif
      end else begin
         tick_q <= 1'b0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            HOLD: begin
               if (hold_done) state_q <= IDLE;
            end
            IDLE: begin
               phase_q <= '0;
               err_q   <= load_bad;
               if (load_ok) begin
                  div_q <= div_in;
                  ack_q <= 1'b1;
               end
               if (run) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
`ifdef TICK_CNT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            RUN: begin
               err_q <= load_bad;
               if (!run) begin
                  // Stopping drops any tick due this edge; a pending or
                  // coincident load takes effect right away.
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  phase_q <= '0;
                  pend_q  <= 1'b0;
                  if (load_ok) begin
                     div_q <= div_in;
                     ack_q <= 1'b1;
                  end else if (pend_q) begin
                     div_q <= pend_val_q;
                     ack_q <= 1'b1;
                  end
               end else if (wrap) begin
                  phase_q <= '0;
                  tick_q  <= 1'b1;
`ifdef TICK_CNT_EN
                  cnt_q   <= sat_inc(cnt_q);
`endif
                  // A load arriving on the wrap edge is deferred to the
                  // next wrap and replaces anything pending.
                  if (load_ok) begin
                     pend_q     <= 1'b1;
                     pend_val_q <= div_in;
                  end else if (pend_q) begin
                     div_q  <= pend_val_q;
                     pend_q <= 1'b0;
                     ack_q  <= 1'b1;
                  end
               end else begin
                  phase_q <= phase_q + 1'b1;
                  if (load_ok) begin
                     pend_q     <= 1'b1;
                     pend_val_q <= div_in;
                  end
               end
            end
            default: state_q <= HOLD;
         endcase
      end
   end

   assign tick    = tick_q;
   assign phase   = phase_q;
   assign div_ack = ack_q;
   assign div_err = err_q;
   assign busy    = busy_q;
`ifdef TICK_CNT_EN
   assign tick_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tick_gen.sv
module tb_tick_gen;

   localparam int DW         = 8;
   localparam int DEF_DIV    = 4;
   localparam int RST_CYCLES = 3;
`ifdef TICK_CNT_EN
   localparam int VW = 5 + DW + 16;
`else
   localparam int VW = 5 + DW;
`endif

   // ---------------- clock / DUT ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run = 1'b0;
   logic          div_load = 1'b0;
   logic [DW-1:0] div_in = '0;
   logic          div_ack, div_err, tick, rst_out, busy;
   logic [DW-1:0] phase;
`ifdef TICK_CNT_EN
   logic [15:0]   tick_cnt;
`endif

   always #5 clk = ~clk;

   tick_gen #(.DW(DW), .DEF_DIV(DEF_DIV), .RST_CYCLES(RST_CYCLES)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .div_load (div_load),
      .div_in   (div_in),
      .div_ack  (div_ack),
      .div_err  (div_err),
      .tick     (tick),
      .phase    (phase),
      .rst_out  (rst_out),
`ifdef TICK_CNT_EN
      .tick_cnt (tick_cnt),
`endif
      .busy     (busy)
   );

   // ---------------- scoreboard ----------------
   logic [VW-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   // Behavioural view: after reset the block waits out a fixed number of
   // cycles, then either sits stopped or counts positions within a period of
   // m_ratio cycles; completing a period emits a tick.
   bit m_in_hold, m_rst_out, m_busy, m_pend, m_tick, m_ack, m_err;
   int m_hold_left, m_ratio, m_pend_val, m_pos, m_cnt;

   function automatic logic [VW-1:0] exp_vec();
      logic [DW-1:0] p;
      p = DW'(m_pos);
`ifdef TICK_CNT_EN
      return {m_rst_out, m_busy, m_tick, m_ack, m_err, p, 16'(m_cnt)};
`else
      return {m_rst_out, m_busy, m_tick, m_ack, m_err, p};
`endif
   endfunction

   function automatic logic [VW-1:0] act_vec();
`ifdef TICK_CNT_EN
      return {rst_out, busy, tick, div_ack, div_err, phase, tick_cnt};
`else
      return {rst_out, busy, tick, div_ack, div_err, phase};
`endif
   endfunction

   task automatic model_step(input bit r, input bit ru, input bit ld, input int din);
      bit good, bad;
      good   = ld && (din != 0);
      bad    = ld && (din == 0);
      m_tick = 0;
      m_ack  = 0;
      m_err  = 0;
      if (r) begin
         m_in_hold   = 1;
         m_hold_left = RST_CYCLES;
         m_rst_out   = 1;
         m_busy      = 0;
         m_ratio     = DEF_DIV;
         m_pend      = 0;
         m_pend_val  = 0;
         m_pos       = 0;
         m_cnt       = 0;
      end else if (m_in_hold) begin
         m_hold_left--;
         if (m_hold_left == 0) begin
            m_in_hold = 0;
            m_rst_out = 0;
         end
      end else begin
         m_err = bad;
         if (!m_busy) begin
            if (good) begin
               m_ratio = din;
               m_ack   = 1;
            end
            m_pos = 0;
            if (ru) begin
               m_busy = 1;
               m_cnt  = 0;
            end
         end else if (!ru) begin
            m_busy = 0;
            m_pos  = 0;
            if (good) begin
               m_ratio = din;
               m_ack   = 1;
            end else if (m_pend) begin
               m_ratio = m_pend_val;
               m_ack   = 1;
            end
            m_pend = 0;
         end else if (m_pos + 1 == m_ratio) begin
            // period complete
            m_pos  = 0;
            m_tick = 1;
            if (m_cnt < 65535) m_cnt++;
            if (good) begin
               m_pend     = 1;
               m_pend_val = din;
            end else if (m_pend) begin
               m_ratio = m_pend_val;
               m_pend  = 0;
               m_ack   = 1;
            end
         end else begin
            m_pos++;
            if (good) begin
               m_pend     = 1;
               m_pend_val = din;
            end
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit r, input bit ru, input bit ld, input int din);
      @(negedge clk);
      rst      = r;
      run      = ru;
      div_load = ld;
      div_in   = DW'(din);
      model_step(r, ru, ld, din);
      exp_q.push_back(exp_vec());
   endtask

   task automatic run_cycles(input int n, input bit ru);
      for (int i = 0; i < n; i++) step(0, ru, 0, 0);
   endtask

   task automatic advance_to(input int ratio, input int pos, input int limit);
      for (int i = 0; i < limit && !(m_busy && m_ratio == ratio && m_pos == pos); i++)
         step(0, 1, 0, 0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [VW-1:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_vec();
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t: got %h expected %h ({rst_out,busy,tick,ack,err,phase[,cnt]})",
                        $time, a, e);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int waitc;
      int dsel, din;
      // reset stretch
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 1, 7);         // ignored during HOLD
      run_cycles(5, 0);
      // basic divide, 20+ ticks
      run_cycles(90, 1);
      // reload during RUN at phase 1
      advance_to(4, 1, 10);
      step(0, 1, 1, 2);
      run_cycles(12, 1);
      // ratio 1, rejected 0, ratio 255
      step(0, 1, 1, 1);
      run_cycles(10, 1);
      step(0, 1, 1, 0);
      run_cycles(5, 1);
      step(0, 1, 1, 255);
      run_cycles(530, 1);
      // back to 4, stop at phase 3
      step(0, 1, 1, 4);
      advance_to(4, 3, 300);
      step(0, 0, 0, 0);
      run_cycles(3, 0);
      // load while idle, overwrite pending, stop with pending
      step(0, 0, 1, 3);
      run_cycles(8, 1);
      step(0, 1, 1, 6);
      step(0, 1, 1, 5);
      run_cycles(12, 1);
      step(0, 1, 1, 2);
      step(0, 0, 0, 0);
      run_cycles(2, 0);
      // mid-run reset
      run_cycles(7, 1);
      step(1, 1, 0, 0);
      run_cycles(10, 1);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         dsel = $urandom_range(0, 3);
         case (dsel)
            0:       din = 0;
            1:       din = $urandom_range(1, 3);
            2:       din = $urandom_range(1, 8);
            default: din = $urandom_range(0, 255);
         endcase
         step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 7) == 0, din);
      end
`ifdef TICK_CNT_EN
      // tick counter: count, clear on restart, saturate
      run_cycles(2, 0);
      step(0, 0, 1, 1);
      run_cycles(11, 1);
      run_cycles(2, 0);
      run_cycles(3, 1);
      run_cycles(65540, 1);
      run_cycles(3, 1);
`endif
      // drain
      waitc = 0;
      while (exp_q.size() > 0 && waitc < 20) begin
         @(posedge clk);
         #2;
         waitc++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
